// File: rtl/riskbes_pkg.sv
// Shared definitions for the divide sequencer: width, divide funct3 codes,
// controller state encoding and small op-decode helpers.
package riskbes_pkg;

    localparam int XLEN = 32;

    // M-extension divide/remainder funct3 encodings
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // funct3[0] selects the unsigned variants
    function automatic logic op_is_unsigned(input logic [2:0] funct3);
        return funct3[0];
    endfunction

    // funct3[1] selects remainder instead of quotient
    function automatic logic op_is_rem(input logic [2:0] funct3);
        return funct3[1];
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, restore on borrow.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The quotient register doubles as the dividend shift register: its MSB
    // is the next dividend bit, and quotient bits enter from the LSB.
    assign shifted = {rem[XLEN-1:0], quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    // Partial remainder is always below the divisor, so the top bit of the
    // XLEN+1 difference is a clean borrow flag.
    always_comb begin
        if (diff[XLEN]) begin
            rem_next = shifted;
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff;
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle divide/remainder controller sitting beside the MDU. Freezes the
// front of the pipeline while a restoring division runs, then presents the
// result until the downstream pipeline is free to take it.
module div_sequencer
    import riskbes_pkg::*;
#(
    parameter int XLEN = riskbes_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    input  logic            busywait_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [XLEN:0]    rem_reg, rem_next;
    logic [XLEN-1:0]  quo_reg, quo_next;
    logic [XLEN-1:0]  dsr_reg, dsr_next;
    logic [XLEN-1:0]  result_reg, result_next;
    logic             is_rem_reg, is_rem_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;

    // Operand decode for the instruction currently presented in EX
    logic            op_unsigned;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            sgn_overflow;
    logic            accept;

    assign op_unsigned  = op_is_unsigned(funct3_i);
    assign op_rem       = op_is_rem(funct3_i);
    assign a_neg        = !op_unsigned && dividend_i[XLEN-1];
    assign b_neg        = !op_unsigned && divisor_i[XLEN-1];
    // Two's-complement negation of MIN_INT wraps back to MIN_INT, which is
    // exactly its unsigned magnitude.
    assign a_mag        = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag        = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign div_zero     = (divisor_i == '0);
    assign sgn_overflow = !op_unsigned && (dividend_i == MIN_INT) && (&divisor_i);
    assign accept       = (state_reg == IDLE) && start_i && !flush_i;

    // Single iteration datapath fed from the working registers
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;

    div_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dsr_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix-up applied to the outputs of the final iteration
    logic [XLEN-1:0] q_final;
    logic [XLEN-1:0] r_final;

    assign q_final = neg_q_reg ? (~step_quo + 1'b1) : step_quo;
    assign r_final = neg_r_reg ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];

    // Next-state and datapath-load decisions; flush overrides everything
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dsr_next    = dsr_reg;
        result_next = result_reg;
        is_rem_next = is_rem_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    is_rem_next = op_rem;
                    neg_q_next  = a_neg ^ b_neg;
                    neg_r_next  = a_neg;
                    rem_next    = '0;
                    quo_next    = a_mag;
                    dsr_next    = b_mag;
                    count_next  = '0;
                    if (div_zero) begin
                        // Quotient all-ones, remainder is the raw dividend
                        result_next = op_rem ? dividend_i : '1;
                        state_next  = DONE;
                    end else if (sgn_overflow) begin
                        result_next = op_rem ? '0 : MIN_INT;
                        state_next  = DONE;
                    end else begin
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                rem_next   = step_rem;
                quo_next   = step_quo;
                count_next = count_reg + 1'b1;
                if (count_reg == CNT_LAST) begin
                    result_next = is_rem_reg ? r_final : q_final;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (!busywait_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush_i) begin
            state_next = IDLE;
            count_next = '0;
        end
    end

    // State and datapath registers; reset clears everything including result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dsr_reg    <= '0;
            result_reg <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dsr_reg    <= dsr_next;
            result_reg <= result_next;
            is_rem_reg <= is_rem_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
        end
    end

    // Stall covers the accept cycle and the whole iteration phase; the
    // result register only changes on entry to DONE, so it holds elsewhere.
    assign stall_o  = !rst_i && (accept || (state_reg == CALC));
    assign valid_o  = (state_reg == DONE);
    assign result_o = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: stimulus pushes expected results into a
// scoreboard; a monitor pops and compares on each rising edge of valid_o.
module tb_div_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        busywait_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;

    div_sequencer #(
        .XLEN (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .busywait_i (busywait_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: compare the presented result once per DONE entry
    logic valid_prev = 1'b0;
    always @(negedge clk_i) begin
        if (valid_o && !valid_prev) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got result 0x%08h with no pending op", result_o);
            end else begin
                sb_item_t it;
                it = sb_q.pop_front();
                if (result_o !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s_result: got 0x%08h expected 0x%08h", it.name, result_o, it.exp);
                end else begin
                    $display("ok   %s_result: 0x%08h", it.name, result_o);
                end
            end
        end
        valid_prev = valid_o;
    end

    // Issue one op at the current negedge (cycle 0) and check the per-cycle
    // handshake; lat is the cycle in which DONE is expected, bw the number of
    // DONE edges held by busywait_i.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input int bw);
        sb_q.push_back('{exp: exp, name: name});
        start_i    = 1'b1;
        funct3_i   = f;
        dividend_i = a;
        divisor_i  = b;
        busywait_i = (bw > 0);
        #1;
        check({name, "_c0_stall"}, {31'd0, stall_o}, 32'd1);
        check({name, "_c0_valid"}, {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (stall_o !== (c < lat) || valid_o !== (c == lat)) begin
                check($sformatf("%s_c%0d_stall_valid", name, c),
                      {30'd0, stall_o, valid_o}, {30'd0, (c < lat), (c == lat)});
            end else if (c == lat) begin
                check($sformatf("%s_c%0d_stall_valid", name, c),
                      {30'd0, stall_o, valid_o}, 32'd1);
            end
            if (c < lat) @(negedge clk_i);
        end
        for (int k = 1; k <= bw; k++) begin
            @(negedge clk_i);
            check($sformatf("%s_hold%0d_valid", name, k), {31'd0, valid_o}, 32'd1);
            check($sformatf("%s_hold%0d_result", name, k), result_o, exp);
            if (k == bw) busywait_i = 1'b0;
        end
        @(negedge clk_i);
        check({name, "_after_valid"}, {31'd0, valid_o}, 32'd0);
    endtask

    // Watch for any valid_o pulse over a window
    task automatic expect_quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        funct3_i   = 3'b000;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;
        busywait_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Normal ops: 34-cycle timing
        run_op("divu_100_7",  3'b101, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu_100_7",  3'b111, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("div_7_m2",    3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run_op("rem_7_m2",    3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        run_op("divu_big_16", 3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 0);
        run_op("remu_big_16", 3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, 0);
        run_op("div_min_2",   3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 0);

        // Special cases: DONE in cycle 1
        run_op("div_5_0",     3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_5_0",     3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("divu_5_0",    3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // busywait held for 3 DONE edges: valid/result visible 4 cycles
        run_op("divu_bw",     3'b101, 32'd100, 32'd7, 32'd14, 33, 3);

        // Flush in CALC cycle 10
        start_i    = 1'b1;
        funct3_i   = 3'b101;
        dividend_i = 32'd500;
        divisor_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("flush_c10_stall", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_next_stall", {31'd0, stall_o}, 32'd0);
        check("flush_next_valid", {31'd0, valid_o}, 32'd0);
        expect_quiet("flush_no_valid", 40);
        run_op("after_flush", 3'b101, 32'd81, 32'd9, 32'd9, 33, 0);

        // Reset in CALC cycle 5
        start_i    = 1'b1;
        funct3_i   = 3'b101;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_calc_stall", {31'd0, stall_o}, 32'd0);
        check("rst_calc_valid", {31'd0, valid_o}, 32'd0);
        check("rst_calc_result", result_o, 32'd0);
        expect_quiet("rst_no_valid", 40);
        @(negedge clk_i);

        // Back-to-back: second op starts in the IDLE cycle right after DONE
        run_op("b2b_first",  3'b101, 32'd1000, 32'd10, 32'd100, 33, 0);
        run_op("b2b_second", 3'b101, 32'd81, 32'd9, 32'd9, 33, 0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog against any unexpected hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
